rvc_asap_5pl_fetch: RTL and testbench

Instruction-fetch stage (Q100H→Q101H) of the rvc_asap 5-stage core.
- Owns the program counter and drives the instruction-memory read address.
- Aligns the memory's one-cycle read data with its PC.
- Absorbs downstream stalls through a one-entry skid buffer.
- Applies branch/jump redirects from Q102H.
- Produces `InstructionQ101H`, which decode consumes and the end-of-test monitor watches for ebreak.

---
 rtl/rvc_asap_5pl_fetch.sv | 124 ++++++++++++
 tb/tb_rvc_asap_5pl_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rvc_asap_5pl_fetch.sv
// rvc_asap_5pl_fetch: Q100H->Q101H fetch stage (PC, memory alignment, stall skid buffer, redirect).
// Optional RVC_FETCH_EBREAK_HALT_EN: halt fetch after delivering ebreak.  Rev 1.0
`default_nettype none

module rvc_asap_5pl_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        Clock,
  input  logic        Rst,
  output logic [31:0] PcQ100H,
  input  logic [31:0] InstFetchQ101H,
  input  logic        StallQ101H,
  input  logic        RedirectQ102H,
  input  logic [31:0] RedirectPcQ102H,
  output logic [31:0] PcQ101H,
  output logic [31:0] InstructionQ101H,
  output logic        ValidQ101H,
  output logic        Halt
);

  localparam logic [31:0] c_EBREAK_INST = 32'h0010_0073;

  logic [31:0] pc100_q, pc100_d;
  logic [31:0] pc101_q, pc101_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;

  logic [31:0] w_inst;
  logic [31:0] w_redir_pc;
  logic        w_halted;
  logic        w_halt_trig;

  assign w_redir_pc = RedirectPcQ102H & 32'hFFFF_FFFC;

`ifdef RVC_FETCH_EBREAK_HALT_EN
  logic halt_q, halt_d;

  assign w_halted    = halt_q;
  assign w_halt_trig = valid_q && !halt_q && !StallQ101H && (w_inst == c_EBREAK_INST);
  assign halt_d      = halt_q | w_halt_trig;
  assign Halt        = halt_q;

  always_ff @(posedge Clock) begin
    if (!Rst) halt_q <= 1'b0;
    else      halt_q <= halt_d;
  end
`else
  assign w_halted    = 1'b0;
  assign w_halt_trig = 1'b0;
  assign Halt        = 1'b0;
`endif

  // Buffered copy wins while the memory is re-reading the stalled address.
  always_comb begin
    w_inst = InstFetchQ101H;
    if (w_halted)                w_inst = NOP_INST;
    else if (buf_valid_q)        w_inst = buf_q;
    else if (kill_q || !valid_q) w_inst = NOP_INST;
  end

  always_comb begin
    pc100_d     = pc100_q;
    pc101_d     = pc101_q;
    valid_d     = valid_q;
    kill_d      = kill_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (w_halted) begin
      valid_d     = 1'b0;
      kill_d      = 1'b0;
      buf_valid_d = 1'b0;
    end else if (w_halt_trig) begin
      // The ebreak is consumed at this edge; freeze the PC behind it.
      valid_d     = 1'b0;
      kill_d      = 1'b0;
      buf_valid_d = 1'b0;
    end else if (RedirectQ102H) begin
      pc100_d     = w_redir_pc;
      valid_d     = 1'b0;
      kill_d      = 1'b1;
      buf_valid_d = 1'b0;
    end else if (StallQ101H) begin
      if (!buf_valid_q) begin
        buf_valid_d = 1'b1;
        buf_d       = w_inst;
      end
    end else begin
      pc101_d     = pc100_q;
      pc100_d     = pc100_q + 32'd4;
      valid_d     = 1'b1;
      kill_d      = 1'b0;
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      pc100_q     <= RESET_PC;
      pc101_q     <= 32'h0;
      valid_q     <= 1'b0;
      kill_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= NOP_INST;
    end else begin
      pc100_q     <= pc100_d;
      pc101_q     <= pc101_d;
      valid_q     <= valid_d;
      kill_q      <= kill_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
    end
  end

  assign PcQ100H          = pc100_q;
  assign PcQ101H          = pc101_q;
  assign InstructionQ101H = w_inst;
  assign ValidQ101H       = valid_q && !w_halted;

endmodule

`default_nettype wire

// File: tb/tb_rvc_asap_5pl_fetch.sv
// Directed self-checking bench for rvc_asap_5pl_fetch; memory returns PC as data (optionally ebreak at 0x10).
`default_nettype none

module tb_rvc_asap_5pl_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBR = 32'h0010_0073;

  logic        Clock = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] PcQ100H;
  logic [31:0] InstFetchQ101H = 32'h0;
  logic        StallQ101H = 1'b0;
  logic        RedirectQ102H = 1'b0;
  logic [31:0] RedirectPcQ102H = 32'h0;
  logic [31:0] PcQ101H;
  logic [31:0] InstructionQ101H;
  logic        ValidQ101H;
  logic        Halt;
  logic        ebreak_en = 1'b0;

  int checks = 0;
  int errors = 0;

  rvc_asap_5pl_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .Clock(Clock), .Rst(Rst), .PcQ100H(PcQ100H), .InstFetchQ101H(InstFetchQ101H),
    .StallQ101H(StallQ101H), .RedirectQ102H(RedirectQ102H), .RedirectPcQ102H(RedirectPcQ102H),
    .PcQ101H(PcQ101H), .InstructionQ101H(InstructionQ101H), .ValidQ101H(ValidQ101H), .Halt(Halt)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock)
    InstFetchQ101H <= (ebreak_en && PcQ100H == 32'h10) ? EBR : PcQ100H;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    step();
    step();
    checks++; if (PcQ100H !== 32'h0) begin errors++; $display("FAIL reset_pc100 got %h exp %h", PcQ100H, 32'h0); end
    checks++; if (PcQ101H !== 32'h0) begin errors++; $display("FAIL reset_pc101 got %h exp %h", PcQ101H, 32'h0); end
    checks++; if (ValidQ101H !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ValidQ101H); end
    checks++; if (InstructionQ101H !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", InstructionQ101H, NOP); end
    checks++; if (Halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", Halt); end
  endtask

  task automatic test_free_run();
    Rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (PcQ101H !== 32'(4*(k-1)) || InstructionQ101H !== 32'(4*(k-1)) || ValidQ101H !== 1'b1)
        begin errors++; $display("FAIL run_%0d got pc=%h inst=%h v=%b exp %h", k, PcQ101H, InstructionQ101H, ValidQ101H, 4*(k-1)); end
      checks++; if (PcQ100H !== 32'(4*k)) begin errors++; $display("FAIL run_pc100_%0d got %h exp %h", k, PcQ100H, 4*k); end
    end
  endtask

  task automatic test_stall();
    StallQ101H = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (PcQ101H !== 32'h8 || InstructionQ101H !== 32'h8 || ValidQ101H !== 1'b1 || PcQ100H !== 32'hC)
        begin errors++; $display("FAIL stall_hold_%0d got pc=%h inst=%h v=%b pc100=%h exp 8/8/1/c", k, PcQ101H, InstructionQ101H, ValidQ101H, PcQ100H); end
    end
    StallQ101H = 1'b0;
    checks++; if (InstructionQ101H !== 32'h8) begin errors++; $display("FAIL stall_release got %h exp 8", InstructionQ101H); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (PcQ101H !== 32'(12 + 4*k) || InstructionQ101H !== 32'(12 + 4*k))
        begin errors++; $display("FAIL stall_after_%0d got pc=%h inst=%h exp %h", k, PcQ101H, InstructionQ101H, 12 + 4*k); end
    end
  endtask

  task automatic test_redirect();
    RedirectQ102H = 1'b1; RedirectPcQ102H = 32'h0000_0203;
    step();
    RedirectQ102H = 1'b0;
    checks++; if (ValidQ101H !== 1'b0 || InstructionQ101H !== NOP)
      begin errors++; $display("FAIL redir_bubble got v=%b inst=%h exp 0/%h", ValidQ101H, InstructionQ101H, NOP); end
    checks++; if (PcQ100H !== 32'h200) begin errors++; $display("FAIL redir_pc100 got %h exp 200", PcQ100H); end
    step();
    checks++; if (PcQ101H !== 32'h200 || InstructionQ101H !== 32'h200 || ValidQ101H !== 1'b1)
      begin errors++; $display("FAIL redir_target got pc=%h inst=%h v=%b exp 200/200/1", PcQ101H, InstructionQ101H, ValidQ101H); end
  endtask

  task automatic test_redirect_stall();
    StallQ101H = 1'b1;
    step();
    RedirectQ102H = 1'b1; RedirectPcQ102H = 32'h0000_0300;
    step();
    RedirectQ102H = 1'b0; StallQ101H = 1'b0;
    checks++; if (ValidQ101H !== 1'b0 || InstructionQ101H !== NOP || PcQ100H !== 32'h300)
      begin errors++; $display("FAIL rs_bubble got v=%b inst=%h pc100=%h exp 0/%h/300", ValidQ101H, InstructionQ101H, PcQ100H, NOP); end
    step();
    checks++; if (PcQ101H !== 32'h300 || InstructionQ101H !== 32'h300 || ValidQ101H !== 1'b1)
      begin errors++; $display("FAIL rs_target got pc=%h inst=%h v=%b exp 300/300/1", PcQ101H, InstructionQ101H, ValidQ101H); end
  endtask

  task automatic test_reset_mid_stall();
    StallQ101H = 1'b1;
    step();
    Rst = 1'b0;
    step();
    checks++; if (PcQ100H !== 32'h0 || ValidQ101H !== 1'b0 || Halt !== 1'b0 || InstructionQ101H !== NOP || PcQ101H !== 32'h0)
      begin errors++; $display("FAIL rst_mid got pc100=%h v=%b h=%b inst=%h pc101=%h exp 0/0/0/%h/0", PcQ100H, ValidQ101H, Halt, InstructionQ101H, PcQ101H, NOP); end
    Rst = 1'b1; StallQ101H = 1'b0;
    step();
    checks++; if (PcQ101H !== 32'h0 || InstructionQ101H !== 32'h0 || ValidQ101H !== 1'b1)
      begin errors++; $display("FAIL rst_restart0 got pc=%h inst=%h v=%b exp 0/0/1", PcQ101H, InstructionQ101H, ValidQ101H); end
    step();
    checks++; if (PcQ101H !== 32'h4 || InstructionQ101H !== 32'h4)
      begin errors++; $display("FAIL rst_restart4 got pc=%h inst=%h exp 4/4", PcQ101H, InstructionQ101H); end
  endtask

  task automatic test_wrap();
    RedirectQ102H = 1'b1; RedirectPcQ102H = 32'hFFFF_FFFF;
    step();
    RedirectQ102H = 1'b0;
    step();
    checks++; if (PcQ101H !== 32'hFFFF_FFFC || PcQ100H !== 32'h0)
      begin errors++; $display("FAIL wrap got pc101=%h pc100=%h exp fffffffc/0", PcQ101H, PcQ100H); end
    step();
    checks++; if (PcQ101H !== 32'h0 || InstructionQ101H !== 32'h0)
      begin errors++; $display("FAIL wrap_next got pc=%h inst=%h exp 0/0", PcQ101H, InstructionQ101H); end
  endtask

  task automatic test_ebreak();
    ebreak_en = 1'b1;
    RedirectQ102H = 1'b1; RedirectPcQ102H = 32'h8;
    step();
    RedirectQ102H = 1'b0;
    step();
    step();
    step();
    checks++; if (PcQ101H !== 32'h10 || InstructionQ101H !== EBR || ValidQ101H !== 1'b1 || PcQ100H !== 32'h14)
      begin errors++; $display("FAIL ebreak_deliver got pc=%h inst=%h v=%b pc100=%h exp 10/%h/1/14", PcQ101H, InstructionQ101H, ValidQ101H, PcQ100H, EBR); end
    step();
`ifdef RVC_FETCH_EBREAK_HALT_EN
    checks++; if (Halt !== 1'b1 || ValidQ101H !== 1'b0 || InstructionQ101H !== NOP || PcQ100H !== 32'h14)
      begin errors++; $display("FAIL halt_set got h=%b v=%b inst=%h pc100=%h exp 1/0/%h/14", Halt, ValidQ101H, InstructionQ101H, PcQ100H, NOP); end
    RedirectQ102H = 1'b1; RedirectPcQ102H = 32'h400;
    step();
    RedirectQ102H = 1'b0;
    step();
    checks++; if (Halt !== 1'b1 || ValidQ101H !== 1'b0 || PcQ100H !== 32'h14)
      begin errors++; $display("FAIL halt_redirect got h=%b v=%b pc100=%h exp 1/0/14", Halt, ValidQ101H, PcQ100H); end
`else
    checks++; if (Halt !== 1'b0 || PcQ101H !== 32'h14 || InstructionQ101H !== 32'h14 || ValidQ101H !== 1'b1 || PcQ100H !== 32'h18)
      begin errors++; $display("FAIL no_halt got h=%b pc=%h inst=%h v=%b pc100=%h exp 0/14/14/1/18", Halt, PcQ101H, InstructionQ101H, ValidQ101H, PcQ100H); end
`endif
    ebreak_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid_stall();
    test_wrap();
    test_ebreak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
